// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared state/owner types and counter widths for the memory port arbiter
package riscv_mem_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
  typedef enum logic {OWN_IF, OWN_DM} arb_owner_t;
  localparam int MEM_LAT_MAX = 7;
  localparam int DSTREAK_MAX = 15;
  // latency counter only ever holds MEM_LAT-1
  localparam int LAT_W = $clog2(MEM_LAT_MAX);
  localparam int STREAK_W = $clog2(DSTREAK_MAX + 1);
endpackage

// File: rtl/mem_arb_select.sv
// mem_arb_select: picks which port is granted from the pending requests and the data streak
module mem_arb_select
  import riscv_mem_pkg::*;
#(
  parameter int MAX_DSTREAK = 4
) (
  input  logic                if_req_i,
  input  logic                dm_req_i,
  input  logic [STREAK_W-1:0] streak_i,
  output arb_owner_t          owner_o
);
  // data has priority unless the fetch port has waited out a full streak
  always_comb owner_o = (if_req_i && streak_i == STREAK_W'(MAX_DSTREAK)) ? OWN_IF :
                        dm_req_i ? OWN_DM : OWN_IF;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between fetch and load/store ports
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LAT     = 1,
  parameter int MAX_DSTREAK = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                dm_stall,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);
  arb_state_t            state_q;
  arb_owner_t            owner_q, gnt_owner;
  logic [LAT_W-1:0]      lat_q;
  logic [STREAK_W-1:0]   streak_q, streak_d;
  logic                  grant, gnt_dm;
  logic                  mem_en_q, mem_we_q, if_valid_q, dm_valid_q;
  logic [DATA_W/8-1:0]   mem_be_q;
  logic [ADDR_W-1:0]     mem_addr_q;
  logic [DATA_W-1:0]     mem_wdata_q, if_rdata_q, dm_rdata_q;

  mem_arb_select #(.MAX_DSTREAK(MAX_DSTREAK)) u_select (
    .if_req_i (if_req),
    .dm_req_i (dm_req),
    .streak_i (streak_q),
    .owner_o  (gnt_owner)
  );

  assign grant  = state_q == IDLE && (if_req || dm_req);
  assign gnt_dm = gnt_owner == OWN_DM;

  // count data grants made while a fetch waits; any fetch-free cycle or fetch grant restarts it
  always_comb streak_d = (!if_req || (grant && !gnt_dm)) ? '0 :
                         (grant && streak_q != STREAK_W'(MAX_DSTREAK)) ? streak_q + 1'b1 : streak_q;

  // issue/wait/response sequencer driving the registered memory strobes and port responses
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      lat_q       <= '0;
      streak_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
    end else begin
      streak_q   <= streak_d;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_valid_q <= 1'b0;
      dm_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (grant) begin
          state_q     <= ISSUE;
          owner_q     <= gnt_owner;
          mem_en_q    <= 1'b1;
          mem_we_q    <= gnt_dm && dm_we;
          mem_be_q    <= gnt_dm ? dm_be : '1;
          mem_addr_q  <= gnt_dm ? dm_addr : if_addr;
          mem_wdata_q <= gnt_dm ? dm_wdata : mem_wdata_q;
        end
        ISSUE: begin
          state_q    <= mem_we_q ? RESP : WAIT;
          dm_valid_q <= mem_we_q;
          lat_q      <= LAT_W'(MEM_LAT - 1);
        end
        WAIT: if (lat_q == '0) begin
          state_q    <= RESP;
          if_rdata_q <= owner_q == OWN_IF ? mem_rdata : if_rdata_q;
          dm_rdata_q <= owner_q == OWN_DM ? mem_rdata : dm_rdata_q;
          if_valid_q <= owner_q == OWN_IF;
          dm_valid_q <= owner_q == OWN_DM;
        end else begin
          lat_q <= lat_q - 1'b1;
        end
        RESP: state_q <= IDLE;
      endcase
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_valid  = dm_valid_q;
  assign if_stall  = if_req && !if_valid_q;
  assign dm_stall  = dm_req && !dm_valid_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized scoreboard bench with a behavioural memory and arbitration model
module tb_mem_port_arbiter;
  localparam int LAT  = 3;
  localparam int MAXS = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [3:0]  dm_be = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_valid, if_stall, dm_valid, dm_stall, mem_en, mem_we;
  logic [3:0]  mem_be;
  int          checks = 0, errors = 0, cyc = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_DSTREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // fetch region is words 0..15 (never written), data region is words 16..63
  function automatic logic [31:0] init_word(input int i);
    return i == 4 ? 32'h0050_0093 : i == 16 ? 32'hDEAD_BEEF : i == 17 ? 32'h0 :
           (32'(i) * 32'h0101_0101) ^ 32'h5A5A_0000;
  endfunction

  // memory with MEM_LAT read latency; random junk whenever no read data is due
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] pd [LAT];
  logic        pv [LAT];
  logic [31:0] junk;
  always @(posedge clk) begin
    junk <= $urandom;
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    pv[0] <= mem_en && !mem_we;
    pd[0] <= mem[mem_addr[7:2]];
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : junk;

  typedef struct { bit dm; int due; } txn_t;
  txn_t        tq[$];
  txn_t        t;
  logic [31:0] exp_if[$], exp_dm[$];
  logic [31:0] p_addr, p_wdata, last_load = '0;
  logic [3:0]  p_be;
  bit          p_dm, p_we, free = 1'b1, rst_prev = 1'b0;
  int          en_due = -1, streak = 0;

  // monitor: predicts each grant from the arbitration rules and checks timing and data
  always @(negedge clk) begin
    if (rst_prev) begin
      chk("reset_ctrl", {24'b0, mem_en, mem_we, mem_be, if_valid, dm_valid}, 32'h0);
      chk("reset_data", mem_addr | mem_wdata | if_rdata | dm_rdata, 32'h0);
    end
    rst_prev = !rst;
    if (!rst) begin
      free = 1'b1;
      en_due = -1;
      tq.delete();
      streak = 0;
    end else begin
      chk("if_stall", if_stall, if_req && !if_valid);
      chk("dm_stall", dm_stall, dm_req && !dm_valid);
      if (mem_en || en_due == cyc) begin
        chk("issue_cycle", mem_en && en_due == cyc, 1);
        if (mem_en) begin
          chk("mem_addr", mem_addr, p_addr);
          chk("mem_we", mem_we, p_we);
          chk("mem_be", mem_be, p_be);
          if (p_we) chk("mem_wdata", mem_wdata, p_wdata);
          tq.push_back('{p_dm, cyc + (p_we ? 1 : LAT + 1)});
        end
        en_due = -1;
      end else chk("mem_we_idle", mem_we, 0);
      if (tq.size() != 0 && tq[0].due < cyc && !(if_valid || dm_valid)) begin
        chk("valid_cycle", cyc, tq[0].due);
        void'(tq.pop_front());
      end
      if (if_valid || dm_valid) begin
        chk("single_valid", if_valid && dm_valid, 0);
        chk("pending_txn", tq.size() != 0, 1);
        if (tq.size() != 0) begin
          t = tq.pop_front();
          chk("valid_port", dm_valid, t.dm);
          chk("valid_cycle", cyc, t.due);
        end
        if (dm_valid) begin
          chk("dm_exp_avail", exp_dm.size() != 0, 1);
          if (exp_dm.size() != 0) chk("dm_rdata", dm_rdata, exp_dm.pop_front());
        end else begin
          chk("if_exp_avail", exp_if.size() != 0, 1);
          if (exp_if.size() != 0) chk("if_rdata", if_rdata, exp_if.pop_front());
        end
      end
      if (free && (if_req || dm_req)) begin
        p_dm    = !(if_req && streak == MAXS) && dm_req;
        p_addr  = p_dm ? dm_addr : if_addr;
        p_we    = p_dm && dm_we;
        p_be    = p_dm ? dm_be : 4'hF;
        p_wdata = dm_wdata;
        en_due  = cyc + 1;
        free    = 1'b0;
        streak  = (!if_req || !p_dm) ? 0 : (streak < MAXS ? streak + 1 : streak);
      end else if (!if_req) streak = 0;
      if (if_valid || dm_valid) free = 1'b1;
    end
  end

  task automatic wait_valid(input bit dm);
    int  n = 0;
    bit  seen = 1'b0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      seen = dm ? dm_valid : if_valid;
    end
    chk("valid_wait", seen, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_seq(input int n, input int maxgap, input int fixed_addr);
    for (int k = 0; k < n; k++) begin
      int gap = $urandom_range(maxgap, 0);
      if (gap > 0) begin
        if_req = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      if_addr = fixed_addr >= 0 ? 32'(fixed_addr) : 32'($urandom_range(15, 0)) << 2;
      exp_if.push_back(ref_mem[if_addr[7:2]]);
      if_req = 1'b1;
      wait_valid(1'b0);
    end
    if_req = 1'b0;
  endtask

  task automatic dm_access(input bit we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] e;
    dm_we = we;
    dm_addr = a;
    dm_be = be;
    dm_wdata = wd;
    e = ref_mem[a[7:2]];
    if (we) begin
      exp_dm.push_back(last_load);
      for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a[7:2]][8*b +: 8] = wd[8*b +: 8];
    end else exp_dm.push_back(e);
    dm_req = 1'b1;
    wait_valid(1'b1);
    if (!we) last_load = e;
  endtask

  task automatic dm_seq(input int n, input int maxgap);
    for (int k = 0; k < n; k++) begin
      int gap = $urandom_range(maxgap, 0);
      if (gap > 0) begin
        dm_req = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      dm_access($urandom_range(2, 0) == 0, 32'($urandom_range(63, 16)) << 2,
                4'($urandom_range(15, 1)), $urandom);
    end
    dm_req = 1'b0;
  endtask

  task automatic load_with_reset(input logic [31:0] a);
    logic [31:0] e;
    int n = 0;
    e = ref_mem[a[7:2]];
    dm_we = 1'b0;
    dm_addr = a;
    dm_be = 4'hF;
    exp_dm.push_back(e);
    dm_req = 1'b1;
    while (!mem_en && n < 50) begin @(negedge clk); n++; end
    chk("reset_issue_seen", mem_en, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    last_load = '0;
    wait_valid(1'b1);
    last_load = e;
    dm_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = init_word(i);
      ref_mem[i] = init_word(i);
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    fetch_seq(1, 0, 32'h10);
    repeat (2) begin @(posedge clk); #1; end
    fork
      fetch_seq(1, 0, 32'h10);
      begin dm_access(1'b0, 32'h40, 4'hF, 32'h0); dm_req = 1'b0; end
    join
    dm_access(1'b1, 32'h44, 4'b0011, 32'h1234_5678);
    dm_req = 1'b0;
    @(posedge clk); #1;
    dm_access(1'b0, 32'h44, 4'hF, 32'h0);
    dm_req = 1'b0;
    chk("store_low_half", last_load, 32'h0000_5678);
    repeat (2) begin @(posedge clk); #1; end
    fork
      fetch_seq(6, 0, -1);
      dm_seq(24, 0);
    join
    repeat (2) begin @(posedge clk); #1; end
    load_with_reset(32'h48);
    repeat (2) begin @(posedge clk); #1; end
    fork
      fetch_seq(40, 3, -1);
      dm_seq(60, 3);
    join
    repeat (LAT + 6) @(posedge clk);
    #1;
    chk("if_drain", exp_if.size(), 0);
    chk("dm_drain", exp_dm.size(), 0);
    chk("txn_drain", tq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between the core's instruction-fetch port and its load/store port, giving the core a unified memory.
- Sits between the `riscv` pipeline and the memory array.
- Sequences each access through an issue/wait/response FSM and drives per-port stall signals into the pipeline.
- Data accesses have priority over fetches; a streak counter prevents fetch starvation.

Parameters:
- ADDR_W, 32: address width, both ports and memory.
- DATA_W, 32: data width.
- MEM_LAT, 1: cycles from `mem_en` to valid `mem_rdata`; legal range 1..7.
- MAX_DSTREAK, 4: maximum consecutive data grants while a fetch is pending; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held with `if_addr` stable until `if_valid`.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetched word, registered.
- if_valid  out  1  one-cycle completion pulse for fetch.
- if_stall  out  1  `if_req && !if_valid`.
- dm_req  in  1  load/store request; held with its attributes until `dm_valid`.
- dm_we  in  1  1 = store.
- dm_be  in  DATA_W/8  store byte enables.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_rdata  out  DATA_W  load data, registered.
- dm_valid  out  1  one-cycle completion pulse for load or store.
- dm_stall  out  1  `dm_req && !dm_valid`.
- mem_en  out  1  memory access strobe, one cycle per transaction.
- mem_we  out  1  memory write enable.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after `mem_en`.

Behaviour:
- Reset (`rst == 0` at a rising edge):
  - FSM goes to IDLE; latency counter and streak counter clear.
  - All registered outputs go to 0: `mem_*`, `if_rdata`, `dm_rdata`, `if_valid`, `dm_valid`.
  - Reset mid-transaction abandons it; no valid pulse is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: select the grant, latch the owner and its attributes into the `mem_*` registers, go to ISSUE.
- Grant rule, evaluated in IDLE:
  - Fetch wins if `if_req` is set and the streak counter equals MAX_DSTREAK.
  - Otherwise data wins if `dm_req` is set; otherwise fetch wins.
- ISSUE (one cycle):
  - `mem_en = 1`; `mem_we = 1` only for a store; `mem_be = dm_be` for data grants, all-ones for fetch.
  - Next state is RESP for a store, otherwise WAIT with the latency counter loaded to MEM_LAT-1.
- WAIT:
  - `mem_en = 0`; the counter decrements each cycle.
  - When the counter is 0, capture `mem_rdata` into the owner's rdata register and go to RESP.
- RESP (one cycle):
  - The owner's valid pulse is 1; go to IDLE.
  - The owner's `req` in this cycle is ignored; it is treated as the completed transaction.
  - Store completion leaves `dm_rdata` unchanged.
- Latency, counted from the cycle the request is sampled in IDLE (cycle 0):
  - Read: `mem_en` in cycle 1, valid in cycle MEM_LAT+2.
  - Store: `mem_en` in cycle 1, valid in cycle 2.
  - Minimum spacing between grants: read MEM_LAT+3 cycles, store 3 cycles.
- Streak counter:
  - Increments (saturating at MAX_DSTREAK) on each data grant while `if_req == 1`.
  - Clears on a fetch grant, and in any cycle with `if_req == 0`.
- Simultaneous requests: exactly one grant per IDLE pass. The loser stays stalled and is re-evaluated at the next IDLE.
- Stalls are combinational from `req` and `valid`. Both may be high at once while the other port is being served.
- `mem_*` registers other than `mem_en`/`mem_we` hold their last values outside ISSUE. `mem_en` and `mem_we` are 0 outside ISSUE.
- Address and write data pass through unmodified; no alignment checking.

Decomposition:
- Package `riscv_mem_pkg`:
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, RESP}.
  - `arb_owner_t` enum {OWN_IF, OWN_DM}.
  - Localparams for the counter widths, derived from MEM_LAT and MAX_DSTREAK.
- One sub-module: `mem_arb_select`, combinational grant selection from `if_req`, `dm_req` and the streak count.
- The FSM, counters and registers stay in `mem_port_arbiter`.

Test Plan:
- Fetch only, MEM_LAT=1, `if_addr = 0x10`, memory word 0x00500093:
  - `mem_en` in cycle 1, `if_valid` in cycle 3, `if_rdata = 0x00500093`, `if_stall` high cycles 0–2.
- Simultaneous `if_req` and `dm_req` load at 0x40 (word 0xDEADBEEF):
  - Data granted first; `dm_valid` in cycle 3.
  - Fetch `mem_en` in cycle 5; `if_valid` in cycle 7.
- Store `dm_addr = 0x44`, `dm_be = 4'b0011`, `dm_wdata = 0x12345678`:
  - `mem_we = 1`, `mem_be = 0011` in cycle 1; `dm_valid` in cycle 2.
  - `dm_rdata` unchanged; a later load of 0x44 returns the low half 0x5678.
- Starvation, MAX_DSTREAK=4, `if_req` and `dm_req` both held high continuously:
  - Grant order is D,D,D,D,F,D,D,D,D,F.
  - The streak counter never exceeds 4.
- MEM_LAT=3 read:
  - `mem_en` in cycle 1, capture in cycle 4, valid in cycle 5.
  - `mem_rdata` garbage before cycle 4 must not appear on `if_rdata`.
- Reset asserted (`rst = 0`) in the WAIT cycle of a load:
  - No `dm_valid`; all outputs 0 on the next edge.
  - After `rst = 1` with `dm_req` still high, the load re-issues from IDLE and completes normally.
